// File: rtl/alu_share_ctrl.sv
// Arbitrates one shared combinational ALU between two requesters (round-robin),
// holds latched operands for SETTLE cycles, then presents a registered result.
module alu_share_ctrl #(
  parameter int WIDTH  = 4,
  parameter int OPW    = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic [OPW-1:0]   alu_option,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             busy,
  output logic [7:0]       ops_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam int CW = $clog2(SETTLE + 1);

  state_t        state;
  logic          last_grant;
  logic          grant;
  logic          accept;
  logic [CW-1:0] settle_cnt;

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant = ~last_grant;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last_grant;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE) begin
      if (grant) req_ready = {req_valid[1], 1'b0};
      else       req_ready = {1'b0, req_valid[0]};
    end
  end

  assign accept = |req_ready;

  // last_grant doubles as the index of the requester currently being served.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      settle_cnt <= '0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      alu_option <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      busy       <= 1'b0;
      ops_done   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            alu_option <= grant ? req_op1 : req_op0;
            alu_in1    <= grant ? req_a1  : req_a0;
            alu_in2    <= grant ? req_b1  : req_b0;
            settle_cnt <= CW'(SETTLE);
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          settle_cnt <= settle_cnt - CW'(1);
          if (settle_cnt == CW'(1)) begin
            rsp_result <= alu_out;
            rsp_cout   <= alu_cout;
            rsp_valid  <= last_grant ? 2'b10 : 2'b01;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[last_grant]) begin
            ops_done  <= ops_done + 8'd1;
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
